// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control sequencer for the ARM-subset datapath.
// Optional MOC wait timeout is built when MOC_TIMEOUT_EN is defined.
module control_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        cond,
  input  logic        moc,
  output logic [3:0]  state,
  output logic [1:0]  ma,
  output logic [1:0]  mb,
  output logic [2:0]  mc,
  output logic        md,
  output logic [4:0]  op,
  output logic        me,
  output logic        mg,
  output logic        rf_ld,
  output logic        ir_ld,
  output logic        mar_ld,
  output logic        mdr_ld,
  output logic        fr_ld,
  output logic        mov,
  output logic        rw,
  output logic        abort
);

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch1 = 4'd1,
    StFetch2 = 4'd2,
    StFetch3 = 4'd3,
    StDecode = 4'd4,
    StDp     = 4'd5,
    StLsAddr = 4'd6,
    StLoad1  = 4'd7,
    StLoad2  = 4'd8,
    StStore1 = 4'd9,
    StStore2 = 4'd10,
    StBranch = 4'd11,
    StLink   = 4'd12
  } state_e;

  state_e state_q, state_d;
  logic   waiting;
  logic   timeout;

  assign waiting = (state_q == StFetch3) || (state_q == StLoad1) || (state_q == StStore2);
  assign state   = state_q;

`ifdef MOC_TIMEOUT_EN
  localparam logic [4:0] TimeoutVal = 5'(TIMEOUT_CYCLES);
  logic [4:0] cnt_q, cnt_d;

  // Counts consecutive moc=0 cycles spent in the current wait state.
  assign timeout = waiting && !moc && (cnt_q >= TimeoutVal);
  assign cnt_d   = (waiting && (state_d == state_q)) ? cnt_q + 5'd1 : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 5'd0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_param;
  assign timeout      = 1'b0;
  assign unused_param = (TIMEOUT_CYCLES != 0);
`endif

  logic unused_ir;
  assign unused_ir = ^{ir[31:28], ir[19:0]};
  assign abort     = timeout;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StReset;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = StReset;
    ma      = 2'd0;
    mb      = 2'd0;
    mc      = 3'd0;
    md      = 1'b0;
    op      = 5'd0;
    me      = 1'b0;
    mg      = 1'b0;
    rf_ld   = 1'b0;
    ir_ld   = 1'b0;
    mar_ld  = 1'b0;
    mdr_ld  = 1'b0;
    fr_ld   = 1'b0;
    mov     = 1'b0;
    rw      = 1'b0;
    unique case (state_q)
      StReset: state_d = StFetch1;
      StFetch1: begin
        ma = 2'd2; md = 1'b1; op = 5'd16; mar_ld = 1'b1;
        state_d = StFetch2;
      end
      StFetch2: begin
        ma = 2'd2; mb = 2'd2; md = 1'b1; op = 5'd4; mc = 3'd3;
        rf_ld = 1'b1; mov = 1'b1; rw = 1'b1;
        state_d = StFetch3;
      end
      StFetch3: begin
        mov = 1'b1; rw = 1'b1; me = 1'b1; mdr_ld = 1'b1;
        ir_ld = moc;
        state_d = moc ? StDecode : (timeout ? StFetch1 : StFetch3);
      end
      StDecode: begin
        if (!cond)                   state_d = StFetch1;
        else if (ir[27:26] == 2'b00) state_d = StDp;
        else if (ir[27:26] == 2'b01) state_d = StLsAddr;
        else if (ir[27:25] == 3'b101) state_d = ir[24] ? StLink : StBranch;
        else                         state_d = StFetch1;
      end
      StDp: begin
        mb    = {1'b0, ir[25]};
        fr_ld = ir[20];
        // Compare/test opcodes only update flags.
        rf_ld = (ir[24:23] != 2'b10);
        state_d = StFetch1;
      end
      StLsAddr: begin
        mb = 2'd1; md = 1'b1; op = ir[23] ? 5'd4 : 5'd2; mar_ld = 1'b1;
        state_d = ir[20] ? StLoad1 : StStore1;
      end
      StLoad1: begin
        mov = 1'b1; rw = 1'b1; me = 1'b1; mdr_ld = 1'b1;
        state_d = moc ? StLoad2 : (timeout ? StFetch1 : StLoad1);
      end
      StLoad2: begin
        mg = 1'b1; rf_ld = 1'b1;
        state_d = StFetch1;
      end
      StStore1: begin
        md = 1'b1; op = 5'd13; mdr_ld = 1'b1;
        state_d = StStore2;
      end
      StStore2: begin
        mov = 1'b1;
        state_d = (moc || timeout) ? StFetch1 : StStore2;
      end
      StBranch: begin
        ma = 2'd2; mb = 2'd1; md = 1'b1; op = 5'd4; mc = 3'd3; rf_ld = 1'b1;
        state_d = StFetch1;
      end
      StLink: begin
        ma = 2'd2; md = 1'b1; op = 5'd16; mc = 3'd2; rf_ld = 1'b1;
        state_d = StBranch;
      end
      default: state_d = StReset;
    endcase
  end

endmodule
